// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared I2C state encoding, R/W constants, quarter indices
//                and the per-state bus level decode.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WDATA    = 4'd4,
        WACK     = 4'd5,
        RDATA    = 4'd6,
        RACK     = 4'd7,
        STOP     = 4'd8
    } i2c_state_t;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    localparam logic [1:0] c_Q0 = 2'd0;
    localparam logic [1:0] c_Q1 = 2'd1;
    localparam logic [1:0] c_Q2 = 2'd2;
    localparam logic [1:0] c_Q3 = 2'd3;

    // Returns {scl, sda_release}; sda_release=1 means the line is not pulled low.
    function automatic logic [1:0] i2c_bus_levels(input i2c_state_t st,
                                                  input logic [1:0] q,
                                                  input logic       tx_bit);
        logic scl_high;
        scl_high = (q == c_Q1) || (q == c_Q2);
        case (st)
            IDLE:                        return 2'b11;
            START:                       return {q != c_Q3, q == c_Q0};
            ADDR, WDATA:                 return {scl_high, tx_bit};
            ADDR_ACK, WACK, RDATA, RACK: return {scl_high, 1'b1};
            STOP:                        return {q != c_Q0, (q == c_Q2) || (q == c_Q3)};
            default:                     return 2'b11;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_tick_gen
//  Description : CLK_DIV quarter-tick divider and 2-bit quarter counter.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       qtick,
    output logic [1:0] quarter
);
    import i2c_pkg::*;

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic [1:0] quarter_q, quarter_d;

    always_comb begin
        qtick     = en && (div_cnt_q == c_DIV_LAST);
        div_cnt_d = div_cnt_q;
        quarter_d = quarter_q;
        if (!en) begin
            div_cnt_d = 8'd0;
            quarter_d = c_Q0;
        end else if (qtick) begin
            div_cnt_d = 8'd0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= 8'd0;
            quarter_q <= c_Q0;
        end else begin
            div_cnt_q <= div_cnt_d;
            quarter_q <= quarter_d;
        end
    end

    assign quarter = quarter_q;

endmodule
`default_nettype wire

// File: rtl/i2c_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_master
//  Description : Single-byte I2C master: START, address+R/W, ACK, one data
//                byte, ACK, STOP. SCL and open-drain SDA are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);
    import i2c_pkg::*;

    i2c_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_err_q, ack_err_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;

    logic       qtick;
    logic [1:0] quarter;
    logic [1:0] quarter_n;
    logic       slot_end;
    logic       sample;
    logic       sda_rel;
    logic       sda_in;

    assign sda_in = sda;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (busy_q),
        .qtick   (qtick),
        .quarter (quarter)
    );

    assign slot_end = qtick && (quarter == c_Q3);
    assign sample   = qtick && (quarter == c_Q1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;

        case (state_q)
            IDLE: begin
                // The cycle carrying done is excluded so a back-to-back start is dropped.
                if (start && !busy_q && !done_q) begin
                    state_d   = START;
                    busy_d    = 1'b1;
                    tx_sr_d   = {addr, rw};
                    rw_d      = rw;
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                    bit_cnt_d = 3'd0;
                end
            end
            START: begin
                if (slot_end) state_d = ADDR;
            end
            ADDR, WDATA: begin
                if (slot_end) begin
                    tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : WACK;
                end
            end
            ADDR_ACK: begin
                if (sample) ack_d = sda_in;
                if (slot_end) begin
                    if (ack_q) begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end else if (rw_q == I2C_RW_READ) begin
                        state_d   = RDATA;
                    end else begin
                        state_d   = WDATA;
                        tx_sr_d   = wdata_q;
                    end
                end
            end
            WACK: begin
                if (sample) ack_d = sda_in;
                if (slot_end) begin
                    ack_err_d = ack_q;
                    state_d   = STOP;
                end
            end
            RDATA: begin
                if (sample) rx_sr_d = {rx_sr_q[6:0], sda_in};
                if (slot_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RACK;
                end
            end
            RACK: begin
                if (slot_end) begin
                    state_d = STOP;
                    rdata_d = rx_sr_q;
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Bus levels are decoded from the next state so scl/sda come straight from flops.
        quarter_n          = qtick ? quarter + 2'd1 : quarter;
        {scl_d, sda_rel}   = i2c_bus_levels(state_d, quarter_n, tx_sr_d[7]);
        sda_oe_d           = ~sda_rel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            tx_sr_q   <= 8'd0;
            rx_sr_q   <= 8'd0;
            wdata_q   <= 8'd0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 8'd0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign ack_err = ack_err_q;
    assign scl     = scl_q;
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master
//  Description : Bench for i2c_master with a behavioural slave, a bus monitor
//                and a transaction-level expectation model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_master;

    localparam int         CLK_DIV   = 4;
    localparam int         c_BUDGET  = 4000;
    localparam logic [6:0] c_MY_ADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ack_err;
    logic       scl;
    wire        sda;

    pullup (sda);

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    always #5 clk = ~clk;

    // Behavioural slave: my_addr 7'h2A, measurement 8'hC3.
    logic [7:0] r_meas = 8'hC3;
    logic       r_slv_drive = 1'b0;
    logic       r_slv_active = 1'b0;
    logic       r_slv_read = 1'b0;
    int         r_slv_nbit = 0;
    logic [7:0] r_slv_addr_sr = 8'd0;
    logic [7:0] r_slv_data_sr = 8'd0;
    logic [7:0] r_slv_data_in = 8'd0;
    logic       r_slv_pscl = 1'b1;
    logic       r_slv_psda = 1'b1;

    assign sda = r_slv_drive ? 1'b0 : 1'bz;

    always @(scl or sda or reset) begin
        if (reset) begin
            r_slv_active = 1'b0;
            r_slv_drive  = 1'b0;
        end else if (scl && r_slv_pscl && (sda != r_slv_psda)) begin
            r_slv_active = !sda;
            r_slv_nbit   = 0;
            r_slv_drive  = 1'b0;
        end else if (scl && !r_slv_pscl && r_slv_active) begin
            r_slv_nbit = r_slv_nbit + 1;
            if (r_slv_nbit <= 8)
                r_slv_addr_sr = {r_slv_addr_sr[6:0], sda};
            else if (r_slv_nbit >= 10 && r_slv_nbit <= 17)
                r_slv_data_sr = {r_slv_data_sr[6:0], sda};
        end else if (!scl && r_slv_pscl && r_slv_active) begin
            if (r_slv_nbit == 8) begin
                if (r_slv_addr_sr[7:1] == c_MY_ADDR) begin
                    r_slv_drive = 1'b1;
                    r_slv_read  = r_slv_addr_sr[0];
                end else begin
                    r_slv_active = 1'b0;
                    r_slv_drive  = 1'b0;
                end
            end else if (r_slv_nbit == 9) begin
                r_slv_drive = r_slv_read ? ~r_meas[7] : 1'b0;
            end else if (r_slv_read && r_slv_nbit >= 10 && r_slv_nbit <= 16) begin
                r_slv_drive = ~r_meas[16 - r_slv_nbit];
            end else if (!r_slv_read && r_slv_nbit == 17) begin
                r_slv_drive   = 1'b1;
                r_slv_data_in = r_slv_data_sr;
            end else begin
                r_slv_drive = 1'b0;
            end
        end
        r_slv_pscl = scl;
        r_slv_psda = sda;
    end

    // Bus monitor: SDA value at every SCL rise, SDA edges while SCL is high.
    bit   m_bits[$];
    int   m_starts = 0;
    int   m_stops  = 0;
    logic m_pscl   = 1'b1;
    logic m_psda   = 1'b1;

    always @(scl or sda) begin
        if (scl && m_pscl && (sda != m_psda)) begin
            if (!sda) m_starts = m_starts + 1;
            else      m_stops  = m_stops + 1;
        end
        if (scl && !m_pscl) m_bits.push_back(sda);
        m_pscl = scl;
        m_psda = sda;
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_txn(input logic [6:0] a, input logic i_rw, input logic [7:0] d,
                           input bit poke);
        bit          match;
        int          exp_lat;
        int          exp_nbits;
        logic [31:0] exp_word;
        logic [31:0] got_word;
        logic [7:0]  exp_byte;
        int          base_bits;
        int          base_starts;
        int          base_stops;
        int          cyc;

        match     = (a == c_MY_ADDR);
        exp_lat   = (match ? 80 : 44) * CLK_DIV + 1;
        exp_byte  = i_rw ? r_meas : d;
        exp_nbits = match ? 19 : 10;
        exp_word  = match ? {13'd0, a, i_rw, 1'b0, exp_byte, i_rw, 1'b0}
                          : {22'd0, a, i_rw, 1'b1, 1'b0};
        if (match && i_rw) exp_rdata = r_meas;

        base_bits   = m_bits.size();
        base_starts = m_starts;
        base_stops  = m_stops;

        @(negedge clk);
        start = 1'b1;
        rw    = i_rw;
        addr  = a;
        wdata = d;
        @(posedge clk);
        cyc = 1;
        #1;
        start = 1'b0;
        check_eq("busy_rise", busy, 1);
        while (!done && cyc < c_BUDGET) begin
            @(posedge clk);
            cyc++;
            #1;
            start = poke && (cyc == 100);
            addr  = ~a;
        end
        check_eq("latency", cyc, exp_lat);
        check_eq("busy_fall", busy, 0);
        check_eq("ack_err", ack_err, !match);
        check_eq("rdata", rdata, exp_rdata);
        if (match && !i_rw) check_eq("slave_data_in", r_slv_data_in, d);

        got_word = 32'd0;
        for (int i = base_bits; i < m_bits.size(); i++) got_word = {got_word[30:0], m_bits[i]};
        check_eq("bus_nbits", m_bits.size() - base_bits, exp_nbits);
        check_eq("bus_bits", got_word, exp_word);
        check_eq("bus_starts", m_starts - base_starts, 1);
        check_eq("bus_stops", m_stops - base_stops, 1);

        if (poke) begin
            start = 1'b1;
            addr  = c_MY_ADDR;
            rw    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check_eq("done_width", done, 0);
            check_eq("start_in_done_ignored", busy, 0);
            repeat (40) @(posedge clk);
            #1;
            check_eq("no_second_txn", m_starts - base_starts, 1);
        end else begin
            @(posedge clk);
            #1;
            check_eq("done_width", done, 0);
        end
    endtask

    task automatic reset_mid_read();
        int cyc;
        int base_bits;
        base_bits = m_bits.size();
        @(negedge clk);
        start = 1'b1;
        rw    = 1'b1;
        addr  = c_MY_ADDR;
        wdata = 8'h00;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while ((m_bits.size() - base_bits) < 14 && cyc < c_BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_rdata_bit3", (m_bits.size() - base_bits) >= 14, 1);
        reset = 1'b1;
        exp_rdata = 8'h00;
        #1;
        check_eq("rst_scl", scl, 1);
        check_eq("rst_sda", sda, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdata", rdata, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] ra;
        logic       rrw;
        logic [7:0] rd;

        reset     = 1'b1;
        start     = 1'b0;
        rw        = 1'b0;
        addr      = 7'd0;
        wdata     = 8'd0;
        exp_rdata = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_rdata", rdata, 0);
        check_eq("reset_ack_err", ack_err, 0);
        check_eq("reset_scl", scl, 1);
        check_eq("reset_sda", sda, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        run_txn(c_MY_ADDR, 1'b1, 8'h00, 1'b0);
        run_txn(c_MY_ADDR, 1'b0, 8'hA5, 1'b1);
        run_txn(7'h11,     1'b0, 8'h3C, 1'b0);
        run_txn(7'h11,     1'b1, 8'h00, 1'b0);

        reset_mid_read();
        repeat (5) @(posedge clk);
        run_txn(c_MY_ADDR, 1'b1, 8'h00, 1'b0);

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                ra = c_MY_ADDR;
            end else begin
                ra = 7'($urandom_range(127, 0));
                if (ra == c_MY_ADDR) ra = 7'h55;
            end
            rrw = 1'($urandom_range(1, 0));
            rd  = 8'($urandom_range(255, 0));
            run_txn(ra, rrw, rd, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
